// File: rtl/systolic_2x2_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_2x2_ctrl
//
// Sequencer for a 2x2 output-stationary systolic multiply array. One start
// request runs a full C = A x B operation: clear the PE accumulators, stream
// K_DIM operand pairs out of four BRAMs into the array edges (row 1 and
// column 1 skewed by one cycle), wait for the wavefront to drain, capture the
// four accumulators and pulse done. The controller never touches the data
// arithmetically; it only gates and delays it.
//
// Parameters
//   DATA_W     element / result width
//   K_DIM      inner dimension, 1..4 (one BRAM word per k)
//   DRAIN_CYC  cycles between the last fetch and capture, 3..15
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   start                        request one multiply (only honoured in IDLE)
//   busy, done                   operation in progress / one-cycle completion
//   mem_en, mem_addr             shared read enable and k address to the BRAMs
//   a0_dout, a1_dout             A row 0 / row 1 BRAM data (1-cycle latency)
//   b0_dout, b1_dout             B col 0 / col 1 BRAM data
//   a0_feed, a1_feed             west edge inputs of pe00 / pe10
//   b0_feed, b1_feed             north edge inputs of pe00 / pe01
//   pe_clr                       accumulator clear to all PEs
//   c00_in .. c11_in             PE accumulator values
//   c00 .. c11                   captured results
//   op_count                     completed-operation counter (wraps)
// ---------------------------------------------------------------------------
module systolic_2x2_ctrl #(
    parameter int DATA_W    = 32,
    parameter int K_DIM     = 2,
    parameter int DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [1:0]        mem_addr,
    input  logic [DATA_W-1:0] a0_dout,
    input  logic [DATA_W-1:0] a1_dout,
    input  logic [DATA_W-1:0] b0_dout,
    input  logic [DATA_W-1:0] b1_dout,
    output logic [DATA_W-1:0] a0_feed,
    output logic [DATA_W-1:0] a1_feed,
    output logic [DATA_W-1:0] b0_feed,
    output logic [DATA_W-1:0] b1_feed,
    output logic              pe_clr,
    input  logic [DATA_W-1:0] c00_in,
    input  logic [DATA_W-1:0] c01_in,
    input  logic [DATA_W-1:0] c10_in,
    input  logic [DATA_W-1:0] c11_in,
    output logic [DATA_W-1:0] c00,
    output logic [DATA_W-1:0] c01,
    output logic [DATA_W-1:0] c10,
    output logic [DATA_W-1:0] c11,
    output logic [15:0]       op_count
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        CAPTURE,
        DONE
    } state_t;

    // Terminal counts held at the counter width so comparisons stay 4 bits.
    localparam logic [3:0] FETCH_LAST = 4'(K_DIM - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

    state_t              state;
    logic   [3:0]        cnt;
    logic                rd_valid;
    logic   [DATA_W-1:0] a1_skew;
    logic   [DATA_W-1:0] b1_skew;

    // Control FSM. All handshake and BRAM outputs are registered: each
    // transition loads the output values that belong to the state being
    // entered, so they are valid for the whole of that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= 2'd0;
            pe_clr   <= 1'b0;
        end else begin
            done     <= 1'b0;
            pe_clr   <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= 2'd0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CLEAR;
                        busy   <= 1'b1;
                        pe_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state    <= FETCH;
                    cnt      <= 4'd0;
                    mem_en   <= 1'b1;
                    mem_addr <= 2'd0;
                end
                FETCH: begin
                    // cnt tracks the k index currently on mem_addr.
                    if (cnt == FETCH_LAST) begin
                        state <= DRAIN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt      <= cnt + 4'd1;
                        mem_en   <= 1'b1;
                        mem_addr <= cnt[1:0] + 2'd1;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= CAPTURE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath side: read-valid tracking, the one-cycle skew for row 1 and
    // column 1, result capture and the operation counter. The skew registers
    // load zero whenever no BRAM data is valid so the array never sees stale
    // operands while draining.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            a1_skew  <= '0;
            b1_skew  <= '0;
            c00      <= '0;
            c01      <= '0;
            c10      <= '0;
            c11      <= '0;
            op_count <= 16'd0;
        end else begin
            rd_valid <= mem_en;
            a1_skew  <= rd_valid ? a1_dout : '0;
            b1_skew  <= rd_valid ? b1_dout : '0;
            if (state == CAPTURE) begin
                c00 <= c00_in;
                c01 <= c01_in;
                c10 <= c10_in;
                c11 <= c11_in;
            end
            op_count <= op_count + {15'd0, state == DONE};
        end
    end

    // Row 0 / column 0 go straight from the BRAM, zeroed outside valid reads.
    assign a0_feed = rd_valid ? a0_dout : '0;
    assign b0_feed = rd_valid ? b0_dout : '0;
    assign a1_feed = a1_skew;
    assign b1_feed = b1_skew;

endmodule

// File: tb/tb_systolic_2x2_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_2x2_ctrl
//
// Testbench for systolic_2x2_ctrl. Around the controller sit a model of the
// four operand BRAMs and a 2x2 grid of multiply-accumulate PEs. A reference
// process tracks each accepted operation as an offset from its start cycle,
// pushes the expected product matrix into a scoreboard queue, and a separate
// monitor compares every controller output on each falling edge, popping the
// scoreboard whenever the controller raises done.
// ---------------------------------------------------------------------------
module tb_systolic_2x2_ctrl;

    localparam int DW       = 32;
    localparam int K        = 2;
    localparam int D        = 4;
    localparam int DONE_OFF = 3 + K + D;

    typedef struct packed {
        logic [DW-1:0] c00;
        logic [DW-1:0] c01;
        logic [DW-1:0] c10;
        logic [DW-1:0] c11;
    } result_t;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, mem_en, pe_clr;
    logic [1:0]    mem_addr;
    logic [DW-1:0] a0_dout = '0, a1_dout = '0, b0_dout = '0, b1_dout = '0;
    logic [DW-1:0] a0_feed, a1_feed, b0_feed, b1_feed;
    logic [DW-1:0] c00, c01, c10, c11;
    logic [15:0]   op_count;

    // PE grid state
    logic [DW-1:0] acc00 = '0, acc01 = '0, acc10 = '0, acc11 = '0;
    logic [DW-1:0] a_east0 = '0, a_east1 = '0, b_south0 = '0, b_south1 = '0;

    // BRAM contents: a_mem[row][k] = A[row][k], b_mem[col][k] = B[k][col]
    logic [DW-1:0] a_mem [2][4];
    logic [DW-1:0] b_mem [2][4];

    // Reference model state
    logic [DW-1:0] cur_a [2][4];
    logic [DW-1:0] cur_b [2][4];
    result_t       sb [$];
    int            p         = 0;
    int            ops_done  = 0;
    logic          rst_q     = 1'b0;
    logic          armed     = 1'b0;
    logic [15:0]   op_base   = 16'd0;
    logic          end_req   = 1'b0;

    // Monitor state
    result_t       last_c    = '0;
    logic          final_chk = 1'b0;
    int            vectors     = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    systolic_2x2_ctrl #(
        .DATA_W    (DW),
        .K_DIM     (K),
        .DRAIN_CYC (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .a0_dout  (a0_dout),
        .a1_dout  (a1_dout),
        .b0_dout  (b0_dout),
        .b1_dout  (b1_dout),
        .a0_feed  (a0_feed),
        .a1_feed  (a1_feed),
        .b0_feed  (b0_feed),
        .b1_feed  (b1_feed),
        .pe_clr   (pe_clr),
        .c00_in   (acc00),
        .c01_in   (acc01),
        .c10_in   (acc10),
        .c11_in   (acc11),
        .c00      (c00),
        .c01      (c01),
        .c10      (c10),
        .c11      (c11),
        .op_count (op_count)
    );

    // Operand BRAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            a0_dout <= a_mem[0][mem_addr];
            a1_dout <= a_mem[1][mem_addr];
            b0_dout <= b_mem[0][mem_addr];
            b1_dout <= b_mem[1][mem_addr];
        end
    end

    // 2x2 array: A moves east, B moves south, each PE accumulates its product.
    always @(posedge clk) begin
        a_east0  <= a0_feed;
        a_east1  <= a1_feed;
        b_south0 <= b0_feed;
        b_south1 <= b1_feed;
        if (pe_clr) begin
            acc00 <= '0;
            acc01 <= '0;
            acc10 <= '0;
            acc11 <= '0;
        end else begin
            acc00 <= acc00 + a0_feed * b0_feed;
            acc01 <= acc01 + a_east0 * b1_feed;
            acc10 <= acc10 + a1_feed * b_south0;
            acc11 <= acc11 + a_east1 * b_south1;
        end
    end

    function automatic result_t refMultiply();
        result_t r;
        logic [DW-1:0] s [2][2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s[i][j] = '0;
                for (int k = 0; k < K; k++)
                    s[i][j] = s[i][j] + a_mem[i][k] * b_mem[j][k];
            end
        r.c00 = s[0][0];
        r.c01 = s[0][1];
        r.c10 = s[1][0];
        r.c11 = s[1][1];
        return r;
    endfunction

    // Reference model: p is the offset of the coming cycle from the accepting
    // start cycle T (0 = idle). Acceptance pushes the expected product.
    initial begin
        forever begin
            @(posedge clk);
            armed = 1'b1;
            rst_q = rst;
            if (!rst) begin
                p        = 0;
                ops_done = 0;
            end else if (p == 0) begin
                if (start) begin
                    for (int i = 0; i < 2; i++)
                        for (int k = 0; k < 4; k++) begin
                            cur_a[i][k] = a_mem[i][k];
                            cur_b[i][k] = b_mem[i][k];
                        end
                    sb.push_back(refMultiply());
                    p = 1;
                end
            end else if (p == DONE_OFF) begin
                p = 0;
                ops_done++;
            end else begin
                p++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // Monitor: expected control timeline derived from p, results from the
    // scoreboard whenever the controller signals done.
    initial begin
        logic          e_busy, e_done, e_clr, e_en;
        logic [1:0]    e_addr;
        logic [DW-1:0] e_a0, e_b0, e_a1, e_b1;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (!rst_q) begin
                    sb.delete();
                    last_c = '0;
                end
                e_busy = (p >= 1) && (p < DONE_OFF);
                e_done = (p == DONE_OFF);
                e_clr  = (p == 1);
                e_en   = (p >= 2) && (p < 2 + K);
                e_addr = e_en ? 2'(p - 2) : 2'd0;
                e_a0   = (p >= 3 && p < 3 + K) ? cur_a[0][2'(p - 3)] : '0;
                e_b0   = (p >= 3 && p < 3 + K) ? cur_b[0][2'(p - 3)] : '0;
                e_a1   = (p >= 4 && p < 4 + K) ? cur_a[1][2'(p - 4)] : '0;
                e_b1   = (p >= 4 && p < 4 + K) ? cur_b[1][2'(p - 4)] : '0;

                checkOutput("busy",     32'(busy),     32'(e_busy));
                checkOutput("done",     32'(done),     32'(e_done));
                checkOutput("pe_clr",   32'(pe_clr),   32'(e_clr));
                checkOutput("mem_en",   32'(mem_en),   32'(e_en));
                checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
                checkOutput("a0_feed",  a0_feed, e_a0);
                checkOutput("b0_feed",  b0_feed, e_b0);
                checkOutput("a1_feed",  a1_feed, e_a1);
                checkOutput("b1_feed",  b1_feed, e_b1);
                checkOutput("op_count", 32'(op_count),
                            32'(16'(op_base + 16'(ops_done))));

                if (done) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL sb_underflow at t=%0t: done with queue depth 0, required depth >= 1",
                                 $time);
                    end else begin
                        last_c = sb.pop_front();
                    end
                end
                checkOutput("c00", c00, last_c.c00);
                checkOutput("c01", c01, last_c.c01);
                checkOutput("c10", c10, last_c.c10);
                checkOutput("c11", c11, last_c.c11);

                if (end_req && !final_chk) begin
                    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
                    final_chk = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic applyReset(input int n);
        rst     = 1'b0;
        op_base = 16'd0;
        tick(n);
        rst     = 1'b1;
    endtask

    task automatic loadMatrices(input logic [DW-1:0] a00, a01, a10, a11,
                                input logic [DW-1:0] b00, b01, b10, b11);
        a_mem[0][0] = a00;  a_mem[0][1] = a01;
        a_mem[1][0] = a10;  a_mem[1][1] = a11;
        b_mem[0][0] = b00;  b_mem[0][1] = b10;
        b_mem[1][0] = b01;  b_mem[1][1] = b11;
    endtask

    task automatic applyStimulus(input int hold, input int gap);
        start = 1'b1;
        tick(hold);
        start = 1'b0;
        tick(gap);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d miscompares so far",
                 miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                a_mem[i][k] = '0;
                b_mem[i][k] = '0;
                cur_a[i][k] = '0;
                cur_b[i][k] = '0;
            end
        tick(1);
        applyReset(3);
        tick(2);

        $display("[TB] basic multiply");
        loadMatrices(1, 2, 3, 4, 5, 6, 7, 8);
        applyStimulus(1, 12);

        $display("[TB] back-to-back with start held");
        loadMatrices(1, 0, 0, 1, 9, 8, 7, 6);
        applyStimulus(12, 12);

        $display("[TB] start pulse while busy");
        loadMatrices(2, 3, 5, 7, 11, 13, 17, 19);
        applyStimulus(1, 3);
        applyStimulus(1, 10);

        $display("[TB] reset mid-drain");
        loadMatrices(4, 3, 2, 1, 1, 2, 3, 4);
        applyStimulus(1, 4);
        applyReset(1);
        tick(2);
        applyStimulus(1, 12);

        $display("[TB] randomized operations");
        for (int n = 0; n < 25; n++) begin
            loadMatrices($urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom);
            start = 1'b1;
            tick($urandom_range(1, 3));
            start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                tick($urandom_range(1, 5));
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                tick($urandom_range(0, 3));
                applyReset(1);
            end
            tick($urandom_range(8, 14));
        end

        $display("[TB] op_count wrap");
        tick(12);
        op_base = 16'hFFFF - 16'(ops_done);
        force dut.op_count = 16'hFFFF;
        tick(1);
        release dut.op_count;
        loadMatrices(1, 1, 1, 1, 1, 1, 1, 1);
        applyStimulus(1, 14);

        end_req = 1'b1;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_2x2_ctrl.md
SYSTOLIC_2X2_CTRL -- requirements
Module: systolic_2x2_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of matrix elements and results.
REQ-002 Parameter K_DIM, default 2, inner dimension; legal range 1..4.
REQ-003 Parameter DRAIN_CYC, default 4, cycles waited after the last fetch before capture; legal range 3..15.
REQ-004 The block SHALL have exactly one clock, clk; rst is synchronous and active-low.
REQ-005 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  request one multiply; sampled only in IDLE
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- mem_en  out  1  read enable to the four operand BRAMs
- mem_addr  out  2  shared BRAM read address (k index)
- a0_dout, a1_dout  in  DATA_W  BRAM data, A row 0 / row 1 (1-cycle read latency)
- b0_dout, b1_dout  in  DATA_W  BRAM data, B col 0 / col 1
- a0_feed, a1_feed  out  DATA_W  array west inputs (pe00, pe10)
- b0_feed, b1_feed  out  DATA_W  array north inputs (pe00, pe01)
- pe_clr  out  1  accumulator clear to all four PEs
- c00_in, c01_in, c10_in, c11_in  in  DATA_W  PE accumulator outputs
- c00, c01, c10, c11  out  DATA_W  captured results
- op_count  out  16  completed-operation counter

Function
REQ-006 States SHALL be IDLE, CLEAR, FETCH, DRAIN, CAPTURE, DONE.
REQ-007 IDLE->CLEAR when start=1; otherwise remain in IDLE.
REQ-008 CLEAR SHALL last 1 cycle with pe_clr=1; all other cycles have pe_clr=0.
REQ-009 FETCH SHALL last K_DIM cycles with mem_en=1 and mem_addr=k, k=0..K_DIM-1; outside FETCH, mem_en=0 and mem_addr=0.
REQ-010 DRAIN SHALL last DRAIN_CYC cycles; CAPTURE SHALL last 1 cycle; DONE SHALL last 1 cycle, then return to IDLE.
REQ-011 busy SHALL be 1 in CLEAR, FETCH, DRAIN and CAPTURE; done SHALL be 1 only in DONE.
REQ-012 The read-valid flag SHALL be mem_en delayed by one cycle; a0_feed/b0_feed = a0_dout/b0_dout when the flag is 1, else 0.
REQ-013 a1_feed/b1_feed SHALL be the gated a1_dout/b1_dout, registered one extra cycle (row/column skew); this register is 0 when the flag is 0.
REQ-014 Feeds SHALL be 0 in every cycle without valid data, so that no extra accumulation occurs during DRAIN.
REQ-015 In CAPTURE, c00..c11 SHALL register c00_in..c11_in; they hold until the next CAPTURE.
REQ-016 op_count SHALL increment by 1 in DONE and wrap from 0xFFFF to 0x0000.
REQ-017 start asserted in any state other than IDLE SHALL be ignored and not queued; start held high across DONE SHALL begin a new operation on the first IDLE cycle.
REQ-018 Latency: for start sampled in IDLE at cycle T, busy=1 for cycles T+1..T+2+K_DIM+DRAIN_CYC, and done=1 at cycle T+3+K_DIM+DRAIN_CYC (defaults: done at T+9).
REQ-019 Result widths SHALL equal DATA_W; the controller performs no arithmetic on data and does not detect overflow.

Reset
REQ-020 When rst=0 at a clock edge, the block SHALL enter IDLE, and busy, done, mem_en, pe_clr and the read-valid flag are 0.
REQ-021 On the same reset, mem_addr, all feeds, the skew registers, c00..c11 and op_count SHALL be 0.
REQ-022 Reset during any state SHALL abort the operation without a done pulse; op_count is cleared.

Verification
REQ-023 A=[[1,2],[3,4]], B=[[5,6],[7,8]] loaded, start pulse at T -> done at T+9; c00=19, c01=22, c10=43, c11=50; op_count=1.
REQ-024 Same operation: mem_addr 0 then 1 with mem_en=1 at T+2/T+3; pe_clr=1 only at T+1; a1_feed lags a0_feed by exactly 1 cycle.
REQ-025 A=identity, B=[[9,8],[7,6]], back-to-back with start held high -> two done pulses 10 cycles apart; both results equal B.
REQ-026 Start pulsed at T+4 during busy -> ignored; exactly one done pulse; results are unchanged from the first operation.
REQ-027 rst=0 at T+5 mid-DRAIN -> next cycle IDLE, all outputs 0, no done pulse; a subsequent start completes correctly.
REQ-028 Force op_count to 0xFFFF, run one operation -> op_count=0x0000 after done.
